// File: rtl/proc_pkg.sv
// Shared constants for the multicycle processor: opcodes, time steps,
// ALU operation codes and instruction-register field positions.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] T3 = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int IR_OP_LSB = 6;
  localparam int IR_RX_LSB = 3;
  localparam int IR_RY_LSB = 0;

  function automatic logic [1:0] alu_of(input logic [2:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] w,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[w] = 1'b1;
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: steps each instruction through T0..T3 and decodes
// the datapath strobes. Define CTRL_LOGIC_OPS_EN to enable and (100) / or (101).
module unidade_controle
  import proc_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IW   = 9
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IW-1:0]   IR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Ain,
  output logic            Gin,
  output logic [1:0]      AluOp,
  output logic            Done,
  output logic [1:0]      Tstep
);

  logic [1:0] tstep_q, tstep_d;
  logic [2:0] op, rx, ry, rout_sel;
  logic       is_alu, rin_en, rout_en;
  logic [7:0] rin_oh, rout_oh;

  assign op = IR[IR_OP_LSB +: 3];
  assign rx = IR[IR_RX_LSB +: 3];
  assign ry = IR[IR_RY_LSB +: 3];

`ifdef CTRL_LOGIC_OPS_EN
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
`else
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
`endif

  always_comb begin
    IRin     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = ry;
    DINout   = 1'b0;
    Gout     = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    AluOp    = ALU_ADD;
    Done     = 1'b0;
    case (tstep_q)
      T0: IRin = Run & Resetn;  // gated so reset masks IRin even with Run high
      T1: begin
        if (is_alu) begin
          rout_en  = 1'b1;
          rout_sel = rx;
          Ain      = 1'b1;
        end else begin
          Done = 1'b1;
          case (op)
            OP_MV: begin
              rout_en = 1'b1;
              rin_en  = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              rin_en = 1'b1;
            end
            default: ;
          endcase
        end
      end
      T2: begin
        if (is_alu) begin
          rout_en = 1'b1;
          Gin     = 1'b1;
          AluOp   = alu_of(op);
        end else begin
          Done = 1'b1;  // only reachable if IR changes mid-instruction; recover to T0
        end
      end
      default: begin
        if (is_alu) begin
          Gout   = 1'b1;
          rin_en = 1'b1;
        end
        Done = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (Done)              tstep_d = T0;
    else if (tstep_q == T0) tstep_d = Run ? T1 : T0;
    else                   tstep_d = tstep_q + 2'd1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) tstep_q <= T0;
    else         tstep_q <= tstep_d;
  end

  dec3to8 u_dec_rin  (.en(rin_en),  .w(rx),       .y(rin_oh));
  dec3to8 u_dec_rout (.en(rout_en), .w(rout_sel), .y(rout_oh));

  assign Rin   = rin_oh[NREG-1:0];
  assign Rout  = rout_oh[NREG-1:0];
  assign Tstep = tstep_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed vector table, a mid-instruction reset
// sequence, then randomized traffic against a step-count reference model.
module tb_unidade_controle;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic [1:0] aluop;
    logic       done;
    logic [1:0] tstep;
  } out_t;

  typedef struct {
    logic       rstn;
    logic       run;
    logic [8:0] ir;
    out_t       exp;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Run = 1'b0;
  logic [8:0] IR = '0;
  logic       IRin, DINout, Gout, Ain, Gin, Done;
  logic [7:0] Rin, Rout;
  logic [1:0] AluOp, Tstep;
  out_t       act;
  int         checks = 0;
  int         failures = 0;

  unidade_controle #(.NREG(8), .IW(9)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
    .Ain(Ain), .Gin(Gin), .AluOp(AluOp), .Done(Done), .Tstep(Tstep)
  );

  always #5 Clock = ~Clock;

  assign act = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AluOp, Done, Tstep};

  function automatic out_t o(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                             input logic dinout, input logic gout, input logic ain,
                             input logic gin, input logic [1:0] aluop, input logic done,
                             input logic [1:0] tstep);
    o = {irin, rin, rout, dinout, gout, ain, gin, aluop, done, tstep};
  endfunction

  // Reference: k = cycles since the Run edge (0 = idle in T0).
  function automatic int instr_len(input logic [2:0] op);
    if (op == 3'd2 || op == 3'd3) return 3;
`ifdef CTRL_LOGIC_OPS_EN
    if (op == 3'd4 || op == 3'd5) return 3;
`endif
    return 1;
  endfunction

  function automatic out_t model(input logic rstn, input logic run, input logic [8:0] ir, input int k);
    logic [2:0] op, rx, ry;
    out_t e;
    op = ir[8:6]; rx = ir[5:3]; ry = ir[2:0];
    e = '0;
    if (!rstn) return e;
    e.tstep = 2'(k);
    if (k == 0) begin
      e.irin = run;
    end else if (instr_len(op) == 3) begin
      if (k == 1) begin e.rout = 8'd1 << rx; e.ain = 1'b1; end
      if (k == 2) begin e.rout = 8'd1 << ry; e.gin = 1'b1; e.aluop = 2'(op - 3'd2); end
      if (k == 3) begin e.rin = 8'd1 << rx; e.gout = 1'b1; e.done = 1'b1; end
    end else begin
      e.done = 1'b1;
      if (op == 3'd0) begin e.rout = 8'd1 << ry; e.rin = 8'd1 << rx; end
      if (op == 3'd1) begin e.dinout = 1'b1; e.rin = 8'd1 << rx; end
    end
    return e;
  endfunction

  task automatic check(input string name, input out_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h (tstep got=%0d want=%0d)", name, act, e, act.tstep, e.tstep);
    end
    checks++;
    if ($countones(Rout) + int'(DINout) + int'(Gout) > 1) begin
      failures++;
      $display("FAIL %s bus_exclusive rout=%b dinout=%b gout=%b want at most one", name, Rout, DINout, Gout);
    end
  endtask

  vec_t vecs[21];

  initial begin
    int k;
    out_t e;
    logic rstn;

    vecs[0]  = '{1'b0, 1'b1, 9'o000, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[1]  = '{1'b0, 1'b1, 9'o000, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[2]  = '{1'b1, 1'b1, 9'o001, o(1, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[3]  = '{1'b1, 1'b0, 9'o001, o(0, 8'h01, 8'h02, 0,0,0,0, 2'd0, 1, 2'd1)};
    vecs[4]  = '{1'b1, 1'b0, 9'o001, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[5]  = '{1'b1, 1'b1, 9'o120, o(1, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[6]  = '{1'b1, 1'b0, 9'o120, o(0, 8'h04, 8'h00, 1,0,0,0, 2'd0, 1, 2'd1)};
    vecs[7]  = '{1'b1, 1'b1, 9'o334, o(1, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[8]  = '{1'b1, 1'b0, 9'o334, o(0, 8'h00, 8'h08, 0,0,1,0, 2'd0, 0, 2'd1)};
    vecs[9]  = '{1'b1, 1'b1, 9'o334, o(0, 8'h00, 8'h10, 0,0,0,1, 2'd1, 0, 2'd2)};
    vecs[10] = '{1'b1, 1'b0, 9'o334, o(0, 8'h08, 8'h00, 0,1,0,0, 2'd0, 1, 2'd3)};
    vecs[11] = '{1'b1, 1'b0, 9'o334, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[12] = '{1'b1, 1'b1, 9'o233, o(1, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[13] = '{1'b1, 1'b1, 9'o233, o(0, 8'h00, 8'h08, 0,0,1,0, 2'd0, 0, 2'd1)};
    vecs[14] = '{1'b1, 1'b1, 9'o233, o(0, 8'h00, 8'h08, 0,0,0,1, 2'd0, 0, 2'd2)};
    vecs[15] = '{1'b1, 1'b1, 9'o233, o(0, 8'h08, 8'h00, 0,1,0,0, 2'd0, 1, 2'd3)};
    vecs[16] = '{1'b1, 1'b1, 9'o400, o(1, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
`ifdef CTRL_LOGIC_OPS_EN
    vecs[17] = '{1'b1, 1'b1, 9'o400, o(0, 8'h00, 8'h01, 0,0,1,0, 2'd0, 0, 2'd1)};
    vecs[18] = '{1'b1, 1'b1, 9'o400, o(0, 8'h00, 8'h01, 0,0,0,1, 2'd2, 0, 2'd2)};
    vecs[19] = '{1'b1, 1'b1, 9'o400, o(0, 8'h01, 8'h00, 0,1,0,0, 2'd0, 1, 2'd3)};
`else
    vecs[17] = '{1'b1, 1'b1, 9'o400, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 1, 2'd1)};
    vecs[18] = '{1'b1, 1'b1, 9'o400, o(1, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};
    vecs[19] = '{1'b1, 1'b1, 9'o400, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 1, 2'd1)};
`endif
    vecs[20] = '{1'b1, 1'b0, 9'o400, o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0)};

    for (int i = 0; i < 21; i++) begin
      @(negedge Clock);
      Resetn = vecs[i].rstn;
      Run    = vecs[i].run;
      IR     = vecs[i].ir;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // add R1,R2 aborted by an asynchronous reset in T2
    @(negedge Clock); IR = 9'o212; Run = 1'b1;
    @(negedge Clock); Run = 1'b0;
    @(negedge Clock); #1;
    check("add_t2", o(0, 8'h00, 8'h04, 0,0,0,1, 2'd0, 0, 2'd2));
    #1; Run = 1'b1; Resetn = 1'b0; #1;
    check("async_rst", o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0));
    @(negedge Clock); Resetn = 1'b1; Run = 1'b0; #1;
    check("post_rst_idle0", o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0));
    @(negedge Clock); #1;
    check("post_rst_idle1", o(0, 8'h00, 8'h00, 0,0,0,0, 2'd0, 0, 2'd0));

    k = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clock);
      rstn = ($urandom % 40) != 0;
      Resetn = rstn;
      Run = ($urandom % 3) != 0;
      if (k == 0 || !rstn) IR = 9'($urandom);
      if (!rstn) k = 0;
      #1;
      e = model(rstn, Run, IR, k);
      check($sformatf("rand%0d", n), e);
      if (!rstn || e.done) k = 0;
      else if (k == 0)     k = Run ? 1 : 0;
      else                 k = k + 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for `processador_multiciclo`. It sequences each instruction through time steps T0–T3 using a 2-bit step counter (`Tstep`). It decodes the 9-bit instruction register and drives the datapath strobes: register load/drive enables, bus source select, ALU control, A/G latch enables and `Done`. It sits beside the datapath (registers R0–R7, A, G, IR, bus mux) inside `processador_multiciclo`. It is the sole owner of the bus-driver selects.

## Interface
Parameters:
- `NREG`, 8: number of general registers; width of `Rin`/`Rout`.
- `IW`, 9: instruction width; fields are `IR[8:6]` opcode III, `IR[5:3]` Rx, `IR[2:0]` Ry.

Ports:
- `Clock`  in  1  single system clock; all state changes on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Run`  in  1  start request; sampled only in T0.
- `IR`  in  IW  instruction register contents from the datapath.
- `IRin`  out  1  load IR from DIN.
- `Rin`  out  NREG  one-hot register load enables.
- `Rout`  out  NREG  one-hot register bus-drive enables.
- `DINout`  out  1  DIN drives bus.
- `Gout`  out  1  G drives bus.
- `Ain`  out  1  load A from bus.
- `Gin`  out  1  load G from ALU.
- `AluOp`  out  2  00 add, 01 sub, 10 and, 11 or.
- `Done`  out  1  last step of current instruction.
- `Tstep`  out  2  current time step, exported for debug and the bench.

## Operation
- `Tstep` is the only state: T0=00, T1=01, T2=10, T3=11. All outputs are combinational decodes of `Tstep`, `IR` and `Run`.
- T0: `IRin = Run`. On an edge with `Run=1`, advance to T1; otherwise stay in T0.
- `mv` (000): T1: `Rout[Ry]`, `Rin[Rx]`, `Done`.
- `mvi` (001): T1: `DINout`, `Rin[Rx]`, `Done`. The immediate word is on DIN during T1.
- `add` (010) / `sub` (011): sequence below. `AluOp` is 00 for add and 01 for sub.
  - T1: `Rout[Rx]`, `Ain`.
  - T2: `Rout[Ry]`, `Gin`, `AluOp` valid.
  - T3: `Gout`, `Rin[Rx]`, `Done`.
- Opcodes 100–111, without the macro: treated as NOP. T1 asserts `Done` only, with no enables.
- Any cycle with `Done=1`: the next edge returns to T0, overriding the counter increment.
- Bus exclusivity: at most one of `Rout[*]`, `DINout`, `Gout` is high in any cycle. T0 drives nothing.
- `Run` outside T0 is ignored.
- `Run` held high continuously gives back-to-back instructions: the T0 following `Done` loads the next IR.
- `Rx == Ry` is legal. `add R3,R3` doubles R3.
- `AluOp` is 00 whenever it is not in use.

## Timing
- Reset: `Resetn` low forces `Tstep=0` immediately, without waiting for a clock edge. While `Resetn` is low, every output is 0, including `IRin` regardless of `Run`.
- Reset mid-instruction aborts the instruction with no further enables. The first edge after release samples `Run` in T0.
- Latency from the `Run` edge to `Done` high: `mv`/`mvi`/NOP 1 cycle, ALU ops 3 cycles. Total instruction period is 2 or 4 cycles including T0.
- `IR` must be stable from T1 until the `Done` cycle. IR is loaded only in T0.

## Configuration
- `CTRL_LOGIC_OPS_EN` defined: opcode 100 = `and`, 101 = `or`. Both use the add/sub three-step sequence with `AluOp` 10 and 11 respectively. Opcodes 110–111 remain NOP.
- `CTRL_LOGIC_OPS_EN` undefined: 100–111 are all NOP. `AluOp` never takes 10 or 11.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`;
  - Tstep encodings `T0`–`T3`;
  - `AluOp` encodings;
  - field positions of IR.
- One sub-module: `dec3to8`, a one-hot decoder with an enable. It is instantiated twice, once for `Rin` from Rx and once for `Rout` from Rx/Ry.

## Test plan
- Reset: hold `Resetn=0` with `Run=1`, then pulse `Clock` → `Tstep=0`, all outputs 0. Release → `IRin=1` in T0.
- `mv R0,R1` (IR=000_000_001), `Run` for 1 cycle → T1 shows `Rout=00000010`, `Rin=00000001`, `Done=1`. Next cycle `Tstep=0`.
- `mvi R2` (IR=001_010_000), DIN=0x0005 → T1 shows `DINout=1`, `Rin=00000100`, `Done=1`. No `Rout` bit is set.
- `sub R3,R4` (IR=011_011_100) → T1 `Rout=00001000`/`Ain`; T2 `Rout=00010000`/`Gin`/`AluOp=01`; T3 `Gout`/`Rin=00001000`/`Done`. Bus-exclusivity assertion passes every cycle.
- Reset asserted mid-instruction: `add` (010_001_010) with `Resetn` pulled low in T2 → `Tstep=0` and `Gin=0` immediately. After release, `Run=0` holds in T0.
- Opcode 100, `Run=1` held for two instructions → NOP (`Done` at T1, no enables) without the macro. With `CTRL_LOGIC_OPS_EN`, T2 shows `AluOp=10`. The second instruction loads at the following T0 (`IRin=1`).
